// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared widths, constants, state type and extension helper for imm_ext_arbiter
package imm_ext_pkg;

    localparam int IMM_W_DEFAULT  = 16;
    localparam int DATA_W_DEFAULT = 32;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Low bits carry the immediate; upper bits replicate its MSB only when sign-extending.
    function automatic logic [DATA_W_DEFAULT-1:0] ext_imm(
        input logic [IMM_W_DEFAULT-1:0] imm,
        input logic                     ext_sel
    );
        ext_imm = {{(DATA_W_DEFAULT-IMM_W_DEFAULT){(ext_sel == EXT_SIGN) & imm[IMM_W_DEFAULT-1]}}, imm};
    endfunction

endpackage

// File: rtl/imm_ext_arbiter_rr_arb2.sv
// rtl/imm_ext_arbiter_rr_arb2.sv - 2-way round-robin arbiter owning the last-winner pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_last;

    // A lone requester always wins; on a tie the one that did not win last time goes.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Priority only moves on an actual transfer, so idle cycles keep the rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            rr_last <= gnt[1];
        end
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// rtl/imm_ext_arbiter.sv - round-robin shared immediate extender with registered valid/ready output (optional IMM_EXT_SHIFT_EN adds shl2 inputs)
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [IMM_W-1:0]  req0_imm,
    input  logic              req0_ext_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [IMM_W-1:0]  req1_imm,
    input  logic              req1_ext_sel,
`ifdef IMM_EXT_SHIFT_EN
    input  logic              req0_shl2,
    input  logic              req1_shl2,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id
);

    state_t            state;
    state_t            state_next;
    logic [1:0]        gnt;
    logic              can_accept;
    logic              xfer;
    logic [IMM_W-1:0]  sel_imm;
    logic              sel_ext;
    logic              sel_shl2;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] next_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (xfer),
        .gnt     (gnt)
    );

    // Output slot can take a new result when empty or when it is being drained this cycle.
    always_comb begin
        can_accept = (state == EMPTY) | out_ready;
        req0_ready = can_accept & gnt[0];
        req1_ready = can_accept & gnt[1];
        xfer       = can_accept & (gnt != 2'b00);
    end

    // Steer the granted requester's operands into the single extension datapath.
    always_comb begin
        sel_imm = gnt[1] ? req1_imm     : req0_imm;
        sel_ext = gnt[1] ? req1_ext_sel : req0_ext_sel;
`ifdef IMM_EXT_SHIFT_EN
        sel_shl2 = gnt[1] ? req1_shl2 : req0_shl2;
`else
        sel_shl2 = 1'b0;
`endif
    end

    generate
        if (IMM_W == IMM_W_DEFAULT && DATA_W == DATA_W_DEFAULT) begin : g_pkg_ext
            assign ext_data = ext_imm(sel_imm, sel_ext);
        end else begin : g_gen_ext
            assign ext_data = {{(DATA_W-IMM_W){(sel_ext == EXT_SIGN) & sel_imm[IMM_W-1]}}, sel_imm};
        end
    endgenerate

    // Word-aligned offsets drop the top two bits and shift in zeros.
    always_comb begin
        next_data = sel_shl2 ? {ext_data[DATA_W-3:0], 2'b00} : ext_data;
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Fill on accept, empty on drain without refill, otherwise hold.
    always_comb begin
        state_next = state;
        out_valid  = (state == FULL);
        case (state)
            EMPTY:   if (xfer) state_next = FULL;
            FULL:    if (out_ready && !xfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Result register loads only on a transfer, so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_id   <= 1'b0;
        end else if (xfer) begin
            out_data <= next_data;
            out_id   <= gnt[1];
        end
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb/tb_imm_ext_arbiter.sv - scoreboard bench for imm_ext_arbiter (IMM_EXT_SHIFT_EN optional)
module tb_imm_ext_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_imm, req1_imm;
    logic        req0_ext_sel, req1_ext_sel;
    logic        req0_shl2, req1_shl2;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_id;

    int errors = 0;
    int checks = 0;

    logic [32:0] sb_q[$];
    logic        m_full;
    logic        m_rr;

    imm_ext_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_imm     (req0_imm),
        .req0_ext_sel (req0_ext_sel),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_imm     (req1_imm),
        .req1_ext_sel (req1_ext_sel),
`ifdef IMM_EXT_SHIFT_EN
        .req0_shl2    (req0_shl2),
        .req1_shl2    (req1_shl2),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic sel, input logic shl);
        logic [31:0] v;
        if (sel) v = 32'($signed(imm));
        else     v = 32'(imm);
`ifdef IMM_EXT_SHIFT_EN
        if (shl) v = v * 4;
`else
        if (shl) v = v;
`endif
        return v;
    endfunction

    // One clock: check handshake against the model at negedge, score outputs, push new expectations.
    task automatic step();
        logic e_can, g0, g1;
        logic [32:0] exp;
        @(negedge clk);
        checks++;
        if (out_valid !== m_full) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_full);
        end
        e_can = !m_full || out_ready;
        g0 = req0_valid && (!req1_valid || m_rr);
        g1 = req1_valid && (!req0_valid || !m_rr);
        checks++;
        if (req0_ready !== (e_can & g0) || req1_ready !== (e_can & g1)) begin
            errors++;
            $display("FAIL ready: got %b%b expected %b%b", req1_ready, req0_ready, e_can & g1, e_can & g0);
        end
        if (m_full && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: output with empty queue, got %h", out_data);
            end else begin
                exp = sb_q.pop_front();
                if ({out_id, out_data} !== exp) begin
                    errors++;
                    $display("FAIL output: got id=%b data=%h expected id=%b data=%h", out_id, out_data, exp[32], exp[31:0]);
                end
            end
        end
        if (e_can && (g0 || g1)) begin
            if (g1) sb_q.push_back({1'b1, ref_ext(req1_imm, req1_ext_sel, req1_shl2)});
            else    sb_q.push_back({1'b0, ref_ext(req0_imm, req0_ext_sel, req0_shl2)});
            m_rr   = g1;
            m_full = 1'b1;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_imm = '0; req1_imm = '0;
        req0_ext_sel = 0; req1_ext_sel = 0;
        req0_shl2 = 0; req1_shl2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1;
        rst_n = 0;
        m_full = 0; m_rr = 1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h id=%b expected 0/0/0", out_valid, out_data, out_id);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sign_ext();
        req0_valid = 1; req0_imm = 16'h8001; req0_ext_sel = 1;
        out_ready = 1;
        step();
        req0_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF8001 || out_id !== 1'b0) begin
            errors++;
            $display("FAIL sign_ext: got v=%b d=%h id=%b expected 1/ffff8001/0", out_valid, out_data, out_id);
        end
        step();
    endtask

    task automatic test_zero_ext();
        req1_valid = 1; req1_imm = 16'h8001; req1_ext_sel = 0;
        step();
        req1_valid = 0;
        checks++;
        if (out_data !== 32'h00008001 || out_id !== 1'b1) begin
            errors++;
            $display("FAIL zero_ext: got d=%h id=%b expected 00008001/1", out_data, out_id);
        end
        step();
    endtask

    task automatic test_round_robin();
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            req0_imm = 16'($urandom); req0_ext_sel = 1'($urandom);
            req1_imm = 16'($urandom); req1_ext_sel = 1'($urandom);
            step();
            checks++;
            if (out_id !== k[0]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got id=%b expected %b", k, out_id, k[0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_d;
        logic        held_id;
        held_d = out_data;
        held_id = out_id;
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_data !== held_d || out_id !== held_id) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h/%b expected %h/%b", k, out_data, out_id, held_d, held_id);
            end
        end
        out_ready = 1;
        step();
        checks++;
        if (out_id !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got id=%b expected 0", out_id);
        end
        req0_valid = 0; req1_valid = 0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        req0_valid = 1; req0_imm = 16'h1234; req0_ext_sel = 0;
        out_ready = 0;
        step();
        req0_valid = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h expected 0/0", out_valid, out_data);
        end
        m_full = 0; m_rr = 1;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        @(posedge clk);
        #1;
        req0_valid = 1; req1_valid = 1;
        req0_imm = 16'h7FFF; req0_ext_sel = 1;
        req1_imm = 16'hFFFF; req1_ext_sel = 1;
        step();
        checks++;
        if (out_id !== 1'b0 || out_data !== 32'h00007FFF) begin
            errors++;
            $display("FAIL reset_tie: got id=%b d=%h expected 0/00007fff", out_id, out_data);
        end
        req0_valid = 0; req1_valid = 0;
        step();
        step();
    endtask

`ifdef IMM_EXT_SHIFT_EN
    task automatic test_shift();
        req1_valid = 1; req1_imm = 16'hFFFF; req1_ext_sel = 1; req1_shl2 = 1;
        step();
        req1_valid = 0; req1_shl2 = 0;
        checks++;
        if (out_data !== 32'hFFFFFFFC) begin
            errors++;
            $display("FAIL shift: got %h expected fffffffc", out_data);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_sign_ext();
        test_zero_ext();
        test_round_robin();
        test_stall();
        test_async_reset();
`ifdef IMM_EXT_SHIFT_EN
        test_shift();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never appeared, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
